// File: rtl/bomberman_draw_engine_if.sv
// bomberman_draw_engine_if: draw commands, ROM port and VGA plot signals around the draw engine
interface bomberman_draw_engine_if;
    logic        copy_enable;
    logic [1:0]  memory_select;
    logic        draw_stage;
    logic        draw_t;
    logic        draw_p1;
    logic        draw_p2;
    logic        tc_enable;
    logic        stage_reset;
    logic [2:0]  tile_type;
    logic [7:0]  p1_x;
    logic [6:0]  p1_y;
    logic [7:0]  p2_x;
    logic [6:0]  p2_y;
    logic [2:0]  rom_data;
    logic [14:0] rom_address;
    logic [1:0]  rom_select;
    logic [8:0]  tile_index;
    logic        all_tiles_drawn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        finished;

    modport master (
        output copy_enable, memory_select, draw_stage, draw_t, draw_p1, draw_p2,
               tc_enable, stage_reset, tile_type, p1_x, p1_y, p2_x, p2_y, rom_data,
        input  rom_address, rom_select, tile_index, all_tiles_drawn, x, y, colour, plot, finished
    );

    modport slave (
        input  copy_enable, memory_select, draw_stage, draw_t, draw_p1, draw_p2,
               tc_enable, stage_reset, tile_type, p1_x, p1_y, p2_x, p2_y, rom_data,
        output rom_address, rom_select, tile_index, all_tiles_drawn, x, y, colour, plot, finished
    );
endinterface

// File: rtl/bomberman_draw_engine.sv
// bomberman_draw_engine: streams background, tile and player sprite pixels from ROM to the VGA adapter
module bomberman_draw_engine #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         TILE_COLS   = 20,
    parameter int         TILE_ROWS   = 15,
    parameter int         P1_SPRITE   = 6,
    parameter int         P2_SPRITE   = 7,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input logic                    clock,
    input logic                    reset,
    bomberman_draw_engine_if.slave bus
);
    localparam logic [7:0]  LAST_X    = 8'(SCREEN_W - 1);
    localparam logic [6:0]  LAST_Y    = 7'(SCREEN_H - 1);
    localparam logic [8:0]  COLS      = 9'(TILE_COLS);
    localparam logic [8:0]  LAST_TILE = 9'(TILE_COLS * TILE_ROWS - 1);
    localparam logic [14:0] ROW_PITCH = 15'(SCREEN_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state_q;
    logic        stage_q, player_q, valid_q, plot_q, finished_q;
    logic [2:0]  sprite_q, colour_q, sprite_d;
    logic [7:0]  bx_q, px_q, x_q, px_d, bx_d;
    logic [6:0]  by_q, py_q, y_q, py_d, by_d;
    logic [8:0]  vx_q, tile_index_q, tile_col, tile_row;
    logic [7:0]  vy_q;
    logic [14:0] rom_address_q, rom_address_d;
    logic [1:0]  rom_select_q;
    logic        accept, wrap_x, last_pix;

    // Request decode, accept-time geometry and next pixel address
    always_comb begin
        accept        = bus.copy_enable && (bus.draw_stage || bus.draw_t || bus.draw_p1 || bus.draw_p2);
        tile_col      = tile_index_q % COLS;
        tile_row      = tile_index_q / COLS;
        sprite_d      = bus.draw_t ? bus.tile_type : bus.draw_p1 ? 3'(P1_SPRITE) : 3'(P2_SPRITE);
        bx_d          = bus.draw_stage ? 8'd0 : bus.draw_t ? 8'({tile_col, 3'b000}) : bus.draw_p1 ? bus.p1_x : bus.p2_x;
        by_d          = bus.draw_stage ? 7'd0 : bus.draw_t ? 7'({tile_row, 3'b000}) : bus.draw_p1 ? bus.p1_y : bus.p2_y;
        wrap_x        = px_q == (stage_q ? LAST_X : 8'd7);
        last_pix      = wrap_x && py_q == (stage_q ? LAST_Y : 7'd7);
        px_d          = wrap_x ? 8'd0 : px_q + 8'd1;
        py_d          = wrap_x ? py_q + 7'd1 : py_q;
        rom_address_d = stage_q ? 15'(py_d) * ROW_PITCH + 15'(px_d) : {6'd0, sprite_q, py_d[2:0], px_d[2:0]};
    end

    // Draw FSM with a one-cycle pixel pipeline aligning position with ROM data
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            stage_q       <= 1'b0;
            player_q      <= 1'b0;
            sprite_q      <= 3'd0;
            bx_q          <= 8'd0;
            by_q          <= 7'd0;
            px_q          <= 8'd0;
            py_q          <= 7'd0;
            rom_address_q <= 15'd0;
            rom_select_q  <= 2'd0;
            valid_q       <= 1'b0;
            vx_q          <= 9'd0;
            vy_q          <= 8'd0;
            plot_q        <= 1'b0;
            finished_q    <= 1'b0;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            colour_q      <= 3'd0;
        end else begin
            valid_q    <= state_q == RUN;
            vx_q       <= {1'b0, bx_q} + {1'b0, px_q};
            vy_q       <= {1'b0, by_q} + {1'b0, py_q};
            plot_q     <= valid_q && vx_q < 9'(SCREEN_W) && vy_q < 8'(SCREEN_H) &&
                          !(player_q && bus.rom_data == TRANSPARENT);
            finished_q <= state_q == DONE;
            if (valid_q) begin
                x_q      <= vx_q[7:0];
                y_q      <= vy_q[6:0];
                colour_q <= bus.rom_data;
            end
            case (state_q)
                IDLE: if (accept) begin
                    state_q       <= RUN;
                    stage_q       <= bus.draw_stage;
                    player_q      <= !bus.draw_stage && !bus.draw_t;
                    sprite_q      <= sprite_d;
                    bx_q          <= bx_d;
                    by_q          <= by_d;
                    px_q          <= 8'd0;
                    py_q          <= 7'd0;
                    rom_address_q <= bus.draw_stage ? 15'd0 : {6'd0, sprite_d, 6'd0};
                    rom_select_q  <= bus.memory_select;
                end
                RUN: if (last_pix) state_q <= FLUSH;
                else begin
                    px_q          <= px_d;
                    py_q          <= py_d;
                    rom_address_q <= rom_address_d;
                end
                FLUSH: state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage tile counter; stage_reset wins over tc_enable
    always_ff @(posedge clock) begin
        if (reset || bus.stage_reset) tile_index_q <= 9'd0;
        else if (bus.tc_enable) tile_index_q <= tile_index_q == LAST_TILE ? 9'd0 : tile_index_q + 9'd1;
    end

    assign bus.rom_address     = rom_address_q;
    assign bus.rom_select      = rom_select_q;
    assign bus.tile_index      = tile_index_q;
    assign bus.all_tiles_drawn = tile_index_q == LAST_TILE;
    assign bus.x               = x_q;
    assign bus.y               = y_q;
    assign bus.colour          = colour_q;
    assign bus.plot            = plot_q;
    assign bus.finished        = finished_q;
endmodule

// File: tb/tb_bomberman_draw_engine.sv
// tb_bomberman_draw_engine: random ROM contents and draw requests checked against a pixel-list model
module tb_bomberman_draw_engine;
    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic [15:0] rel;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bomberman_draw_engine_if bus();
    bomberman_draw_engine dut (.clock(clk), .reset(rst), .bus(bus));

    logic [2:0] rom_tab [32768];
    pix_t obs[$];
    pix_t exp_q[$];
    int edges = 0, acc_e = 0, fin_cnt = 0, fin_rel = 0;
    int checks = 0, errors = 0, tidx = 0;

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk) bus.rom_data <= rom_tab[bus.rom_address];

    always @(negedge clk) begin
        if (bus.plot === 1'b1) obs.push_back({bus.x, bus.y, bus.colour, 16'(edges - acc_e)});
        if (bus.finished === 1'b1) begin
            fin_cnt++;
            fin_rel = edges - acc_e;
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic build_exp(input bit stage, input bit player, input int sprite, input int bx, input int by, output int n);
        int w, h, addr;
        logic [2:0] c;
        w = stage ? 160 : 8;
        h = stage ? 120 : 8;
        exp_q.delete();
        n = 0;
        for (int py = 0; py < h; py++)
            for (int px = 0; px < w; px++) begin
                addr = stage ? py * 160 + px : sprite * 64 + py * 8 + px;
                c = rom_tab[addr];
                if (!(player && c == 3'b000) && bx + px < 160 && by + py < 120)
                    exp_q.push_back({8'(bx + px), 7'(by + py), c, 16'(n + 2)});
                n++;
            end
    endtask

    task automatic pulse_tc(input bit sr);
        bus.tc_enable = 1'b1;
        bus.stage_reset = sr;
        @(negedge clk);
        bus.tc_enable = 1'b0;
        bus.stage_reset = 1'b0;
        tidx = sr ? 0 : (tidx == 299 ? 0 : tidx + 1);
    endtask

    task automatic run_draw(input logic [3:0] d, input logic [1:0] msel, input bit chain, input bit tc_mid, input string tag);
        int n, i, base_o, base_f, sprite, bx, by;
        bit stage, player;
        stage = d[3];
        player = !d[3] && !d[2];
        sprite = d[2] ? int'(bus.tile_type) : d[1] ? 6 : 7;
        bx = d[3] ? 0 : d[2] ? (tidx % 20) * 8 : d[1] ? int'(bus.p1_x) : int'(bus.p2_x);
        by = d[3] ? 0 : d[2] ? (tidx / 20) * 8 : d[1] ? int'(bus.p1_y) : int'(bus.p2_y);
        build_exp(stage, player, sprite, bx, by, n);
        bus.copy_enable = 1'b1;
        {bus.draw_stage, bus.draw_t, bus.draw_p1, bus.draw_p2} = d;
        bus.memory_select = msel;
        @(negedge clk);
        acc_e = edges;
        #1;
        base_o = obs.size();
        base_f = fin_cnt;
        chk({tag, " rom_select"}, 64'(bus.rom_select), 64'(msel));
        i = 0;
        while (bus.finished !== 1'b1 && i < n + 20) begin
            if (i < 10) begin
                bus.copy_enable = 1'($urandom);
                {bus.draw_stage, bus.draw_t, bus.draw_p1, bus.draw_p2} = 4'($urandom);
                bus.tile_type = 3'($urandom);
                bus.p1_x = 8'($urandom);
                bus.p2_y = 7'($urandom);
            end else begin
                bus.copy_enable = 1'b0;
                {bus.draw_stage, bus.draw_t, bus.draw_p1, bus.draw_p2} = 4'b0000;
            end
            bus.tc_enable = tc_mid && i == 3;
            if (tc_mid && i == 3) tidx = tidx == 299 ? 0 : tidx + 1;
            @(negedge clk);
            i++;
        end
        #1;
        chk({tag, " finish seen"}, 64'(bus.finished === 1'b1), 64'(1));
        if (!chain) repeat (3) @(negedge clk);
        #1;
        chk({tag, " finished count"}, 64'(fin_cnt - base_f), 64'(1));
        chk({tag, " finished cycle"}, 64'(fin_rel), 64'(n + 2));
        chk({tag, " plot count"}, 64'(obs.size() - base_o), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < obs.size() - base_o; j++) begin
            chk($sformatf("%s pixel %0d", tag, j), 64'(obs[base_o + j]), 64'(exp_q[j]));
            if (obs[base_o + j] !== exp_q[j]) break;
        end
    endtask

    initial begin
        int base_o, base_f, i;
        logic [1:0] sel_before;
        for (int a = 0; a < 32768; a++) rom_tab[a] = 3'($urandom);
        bus.copy_enable = 1'b0;
        bus.memory_select = 2'd0;
        {bus.draw_stage, bus.draw_t, bus.draw_p1, bus.draw_p2} = 4'b0000;
        bus.tc_enable = 1'b0;
        bus.stage_reset = 1'b0;
        bus.tile_type = 3'd0;
        bus.p1_x = 8'd0;
        bus.p1_y = 7'd0;
        bus.p2_x = 8'd0;
        bus.p2_y = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset plot", 64'(bus.plot), 64'(0));
        chk("reset finished", 64'(bus.finished), 64'(0));
        chk("reset xy colour", 64'({bus.x, bus.y, bus.colour}), 64'(0));
        chk("reset rom_address", 64'(bus.rom_address), 64'(0));
        chk("reset rom_select", 64'(bus.rom_select), 64'(0));
        chk("reset tile_index", 64'(bus.tile_index), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_draw(4'b1000, 2'd1, 1'b0, 1'b0, "stage copy");

        repeat (21) pulse_tc(1'b0);
        chk("tile_index 21", 64'(bus.tile_index), 64'(tidx));
        bus.tile_type = 3'd3;
        run_draw(4'b0100, 2'd1, 1'b0, 1'b0, "tile 21");

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 60)) pulse_tc(1'b0);
            bus.tile_type = 3'($urandom);
            run_draw(4'b0100, 2'($urandom), 1'b0, 1'b1, "rand tile");
        end

        bus.stage_reset = 1'b1;
        @(negedge clk);
        bus.stage_reset = 1'b0;
        tidx = 0;
        for (int k = 0; k < 300; k++) begin
            chk("tile index walk", 64'(bus.tile_index), 64'(tidx));
            chk("all_tiles_drawn", 64'(bus.all_tiles_drawn), 64'(tidx == 299));
            pulse_tc(1'b0);
        end
        chk("tile wrap", 64'(bus.tile_index), 64'(tidx));
        repeat (5) pulse_tc(1'b0);
        pulse_tc(1'b1);
        chk("stage_reset over tc_enable", 64'(bus.tile_index), 64'(tidx));

        for (int a = 0; a < 64; a++) rom_tab[6 * 64 + a] = (a % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        bus.p1_x = 8'd156;
        bus.p1_y = 7'd116;
        run_draw(4'b0010, 2'd3, 1'b0, 1'b0, "p1 clip transparent");

        bus.p1_x = 8'($urandom_range(0, 159));
        bus.p1_y = 7'($urandom_range(0, 119));
        bus.p2_x = 8'($urandom_range(0, 159));
        bus.p2_y = 7'($urandom_range(0, 119));
        run_draw(4'b0010, 2'd3, 1'b1, 1'b0, "b2b p1");
        run_draw(4'b0001, 2'd3, 1'b0, 1'b0, "b2b p2");

        bus.tile_type = 3'($urandom);
        run_draw(4'b0110, 2'd2, 1'b0, 1'b0, "prio tile over p1");
        bus.p1_x = 8'($urandom_range(0, 159));
        bus.p1_y = 7'($urandom_range(0, 119));
        run_draw(4'b0011, 2'd3, 1'b0, 1'b0, "prio p1 over p2");

        for (int r = 0; r < 6; r++) begin
            bus.p1_x = 8'($urandom);
            bus.p1_y = 7'($urandom);
            bus.p2_x = 8'($urandom);
            bus.p2_y = 7'($urandom);
            run_draw($urandom_range(0, 1) ? 4'b0010 : 4'b0001, 2'($urandom), 1'b0, 1'b0, "rand player");
        end

        sel_before = bus.rom_select;
        base_o = obs.size();
        base_f = fin_cnt;
        bus.copy_enable = 1'b1;
        bus.memory_select = ~sel_before;
        repeat (80) @(negedge clk);
        bus.copy_enable = 1'b0;
        #1;
        chk("copy_enable alone plots", 64'(obs.size() - base_o), 64'(0));
        chk("copy_enable alone finished", 64'(fin_cnt - base_f), 64'(0));
        chk("copy_enable alone rom_select", 64'(bus.rom_select), 64'(sel_before));

        bus.memory_select = 2'd1;
        bus.copy_enable = 1'b1;
        bus.draw_stage = 1'b1;
        @(negedge clk);
        acc_e = edges;
        #1;
        base_o = obs.size();
        base_f = fin_cnt;
        bus.copy_enable = 1'b0;
        bus.draw_stage = 1'b0;
        i = 0;
        while (obs.size() - base_o < 500 && i < 1000) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("mid reset reached pixel 500", 64'(obs.size() - base_o >= 500), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid reset plot", 64'(bus.plot), 64'(0));
        chk("mid reset finished", 64'(bus.finished), 64'(0));
        chk("mid reset xy colour", 64'({bus.x, bus.y, bus.colour}), 64'(0));
        chk("mid reset rom_address", 64'(bus.rom_address), 64'(0));
        chk("mid reset rom_select", 64'(bus.rom_select), 64'(0));
        chk("mid reset tile_index", 64'(bus.tile_index), 64'(0));
        rst = 1'b0;
        tidx = 0;
        base_o = obs.size();
        repeat (300) @(negedge clk);
        #1;
        chk("mid reset no finished", 64'(fin_cnt - base_f), 64'(0));
        chk("mid reset no plots", 64'(obs.size() - base_o), 64'(0));
        repeat (7) pulse_tc(1'b0);
        bus.tile_type = 3'($urandom);
        run_draw(4'b0100, 2'd1, 1'b0, 1'b0, "after reset tile");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
